// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: instruction formats, encoder FSM states
// and field bit positions (also used by the ID-stage field decoder).
package mips_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int TGT_HI = 25, TGT_LO = 0;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields + format -> 32-bit word.
// o_legal is low for the illegal format; the word is then all zeros.
module instr_pack
  import mips_pkg::*;
(
  input  logic [1:0]  i_fmt,
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_func,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // Place each field at its decoder bit position; unused fields are ignored.
  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (i_fmt)
      FMT_R: begin
        o_word[OP_HI:OP_LO] = i_op;
        o_word[RS_HI:RS_LO] = i_rs;
        o_word[RT_HI:RT_LO] = i_rt;
        o_word[RD_HI:RD_LO] = i_rd;
        o_word[SH_HI:SH_LO] = i_shamt;
        o_word[FN_HI:FN_LO] = i_func;
      end
      FMT_I: begin
        o_word[OP_HI:OP_LO]   = i_op;
        o_word[RS_HI:RS_LO]   = i_rs;
        o_word[RT_HI:RT_LO]   = i_rt;
        o_word[IMM_HI:IMM_LO] = i_imm;
      end
      FMT_J: begin
        o_word[OP_HI:OP_LO]   = i_op;
        o_word[TGT_HI:TGT_LO] = i_target;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction loader: accepts field tuples over valid/ready,
// packs them and writes them to consecutive instruction memory words.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  input  logic [15:0]       immediate,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = '1;

  enc_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_we, r_done, r_full, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_wc;
  logic              w_ready, w_acc, w_wr, w_bad, w_legal;
  logic [31:0]       w_word;

  instr_pack u_pack (
    .i_fmt    (fmt),
    .i_op     (op),
    .i_rs     (rs),
    .i_rt     (rt),
    .i_rd     (rd),
    .i_shamt  (shamt),
    .i_func   (func),
    .i_imm    (immediate),
    .i_target (target),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  // A start in the same cycle blocks acceptance so a reload never races a write.
  assign w_ready = (r_state == ST_LOAD) && !start;
  assign w_acc   = in_valid && w_ready;
  assign w_wr    = w_acc && w_legal;
  assign w_bad   = w_acc && !w_legal;

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state; start overrides everything, including a concurrent finish.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_IDLE;
      ST_LOAD: begin
        if (finish)                          w_next = ST_IDLE;
        else if (w_wr && (r_ptr == LP_LAST)) w_next = ST_FULL;
      end
      ST_FULL: if (finish) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (start) w_next = ST_LOAD;
  end

  // Write register, address counter and session status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ptr   <= LP_BASE;
      r_wc    <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= w_wr;
      r_done <= finish && !start && (r_state != ST_IDLE);
      if (start) begin
        r_ptr  <= LP_BASE;
        r_wc   <= '0;
        r_full <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_wr) begin
          r_addr  <= r_ptr;
          r_wdata <= w_word;
          r_wc    <= r_wc + 1'b1;
          // The last word pins the counter rather than wrapping it.
          if (r_ptr == LP_LAST) r_full <= 1'b1;
          else                  r_ptr  <= r_ptr + 1'b1;
        end
        if (w_bad) r_err <= 1'b1;
      end
    end
  end

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign full       = r_full;
  assign err        = r_err;
  assign word_count = r_wc;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a small ADDR_W so the full
// condition is reachable: directed cases followed by random sessions.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    fmt = '0;
  logic [5:0]    op = '0, func = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0]   immediate = '0;
  logic [25:0]   target = '0;
  logic          imem_we, done, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .immediate(immediate), .target(target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done),
    .full(full), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  f;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
  } tup_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [AW:0]   wc;
  } wr_t;

  wr_t           q[$];
  int            total = 0, bad = 0;
  bit            m_act = 0, m_full = 0, m_err = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_la = '0;
  logic [31:0]   m_ld = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding from the field weights of each format.
  function automatic logic [31:0] enc(input tup_t t);
    logic [31:0] w;
    case (t.f)
      2'd0: w = 32'(t.op) * 32'h0400_0000 + 32'(t.rs) * 32'h0020_0000
              + 32'(t.rt) * 32'h0001_0000 + 32'(t.rd) * 32'h800
              + 32'(t.sh) * 32'd64 + 32'(t.fn);
      2'd1: w = 32'(t.op) * 32'h0400_0000 + 32'(t.rs) * 32'h0020_0000
              + 32'(t.rt) * 32'h0001_0000 + 32'(t.imm);
      default: w = 32'(t.op) * 32'h0400_0000 + 32'(t.tgt);
    endcase
    return w;
  endfunction

  function automatic tup_t mk(input logic [1:0] f, input logic [5:0] o,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] im,
                              input logic [25:0] tg);
    tup_t r;
    r.f = f; r.op = o; r.rs = s; r.rt = t; r.rd = d; r.sh = sh;
    r.fn = fn; r.imm = im; r.tgt = tg;
    return r;
  endfunction

  function automatic tup_t rnd_tup();
    tup_t r;
    r.f   = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
    r.op  = 6'($urandom); r.rs = 5'($urandom); r.rt = 5'($urandom);
    r.rd  = 5'($urandom); r.sh = 5'($urandom); r.fn = 6'($urandom);
    r.imm = 16'($urandom); r.tgt = 26'($urandom);
    return r;
  endfunction

  // One clock of stimulus: drive, predict, step the model, check after the edge.
  task automatic cyc(input bit st, input bit fin, input bit vld, input tup_t t,
                     input bit uk, input logic [31:0] k);
    bit  rdy, dn;
    wr_t e;
    start = st; finish = fin; in_valid = vld; fmt = t.f; op = t.op;
    rs = t.rs; rt = t.rt; rd = t.rd; shamt = t.sh; func = t.fn;
    immediate = t.imm; target = t.tgt;
    #1;
    rdy = m_act && !m_full && !st;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    dn = 0;
    if (vld && rdy) begin
      if (t.f == 2'd3) m_err = 1;
      else begin
        e.a = AW'(m_cnt);
        e.d = uk ? k : enc(t);
        m_cnt++;
        e.wc = (AW+1)'(m_cnt);
        q.push_back(e);
        if (m_cnt == DEPTH) m_full = 1;
      end
    end
    if (st) begin
      m_act = 1; m_cnt = 0; m_full = 0; m_err = 0;
    end else if (fin && m_act) begin
      m_act = 0; dn = 1;
    end
    @(posedge clk); #1;
    chk("done", 64'(done), 64'(dn));
    chk("err", 64'(err), 64'(m_err));
    chk("full", 64'(full), 64'(m_full));
    chk("word_count", 64'(word_count), 64'(m_cnt));
  endtask

  tup_t nul;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, nul, 0, 0);
  endtask

  task automatic put(input tup_t t, input logic [31:0] k);
    cyc(0, 0, 1, t, 1, k);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (imem_we) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write addr=%0h data=%0h want=none", imem_addr, imem_wdata);
        end else begin
          e = q.pop_front();
          chk("imem_addr", 64'(imem_addr), 64'(e.a));
          chk("imem_wdata", 64'(imem_wdata), 64'(e.d));
          chk("wc_at_write", 64'(word_count), 64'(e.wc));
          m_la = e.a; m_ld = e.d;
        end
      end else begin
        chk("addr_hold", 64'(imem_addr), 64'(m_la));
        chk("wdata_hold", 64'(imem_wdata), 64'(m_ld));
      end
    end
  end

  initial begin
    nul = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(imem_we), 0);
    chk("rst_addr", 64'(imem_addr), 0);
    chk("rst_wdata", 64'(imem_wdata), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_wc", 64'(word_count), 0);
    chk("rst_ready", 64'(in_ready), 0);
    rst_n = 1'b1;
    // Idle state ignores valid tuples.
    cyc(0, 0, 1, mk(0, 0, 1, 2, 3, 0, 6'h20, 0, 0), 0, 0);

    // Encodings, back-to-back, then full.
    cyc(1, 0, 0, nul, 0, 0);
    put(mk(0, 6'h00, 1, 2, 3, 0, 6'h20, 0, 0), 32'h00221820);
    put(mk(1, 6'h08, 0, 8, 0, 0, 0, 16'd5, 0), 32'h20080005);
    put(mk(1, 6'h23, 29, 8, 0, 0, 0, 16'd4, 0), 32'h8FA80004);
    put(mk(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h10), 32'h08000010);
    cyc(0, 0, 1, mk(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h11), 0, 0);
    cyc(0, 1, 0, nul, 0, 0);
    cyc(0, 0, 1, mk(1, 1, 1, 1, 0, 0, 0, 1, 0), 0, 0);

    // Illegal format between two legal tuples; err sticks until start.
    cyc(1, 0, 0, nul, 0, 0);
    put(mk(1, 6'h08, 0, 8, 0, 0, 0, 16'd5, 0), 32'h20080005);
    cyc(0, 0, 1, mk(3, 6'h3f, 31, 31, 31, 31, 6'h3f, 16'hffff, 26'h3ffffff), 0, 0);
    put(mk(0, 6'h00, 1, 2, 3, 0, 6'h20, 0, 0), 32'h00221820);
    cyc(0, 1, 0, nul, 0, 0);
    idle(2);

    // Finish together with a valid tuple; then start mid-session.
    cyc(1, 0, 0, nul, 0, 0);
    cyc(0, 1, 1, mk(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'h2abcdef), 1, 32'h0EABCDEF);
    cyc(1, 0, 0, nul, 0, 0);
    cyc(0, 0, 1, rnd_tup(), 0, 0);
    cyc(0, 0, 1, mk(0, 0, 4, 5, 6, 7, 6'h2a, 0, 0), 0, 0);
    cyc(1, 1, 1, mk(0, 0, 4, 5, 6, 7, 6'h2a, 0, 0), 0, 0);
    put(mk(1, 6'h23, 29, 8, 0, 0, 0, 16'd4, 0), 32'h8FA80004);

    // Reset with a write on the bus: outputs clear at once, nothing follows.
    cyc(0, 0, 1, mk(1, 6'h0d, 3, 4, 0, 0, 0, 16'h1234, 0), 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(imem_we), 0);
    chk("mid_rst_addr", 64'(imem_addr), 0);
    chk("mid_rst_wdata", 64'(imem_wdata), 0);
    chk("mid_rst_wc", 64'(word_count), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    q.delete();
    m_act = 0; m_cnt = 0; m_full = 0; m_err = 0; m_la = '0; m_ld = '0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 1, mk(0, 1, 1, 1, 1, 1, 1, 0, 0), 0, 0);
    cyc(0, 1, 1, mk(0, 1, 1, 1, 1, 1, 1, 0, 0), 0, 0);

    // Random sessions.
    cyc(1, 0, 0, nul, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit st, fin, vld;
      st  = ($urandom_range(99) < 4);
      fin = ($urandom_range(99) < 6);
      vld = ($urandom_range(99) < 75);
      cyc(st, fin, vld, rnd_tup(), 0, 0);
    end
    cyc(0, 1, 0, nul, 0, 0);
    idle(3);
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded MIPS field tuples (op, rs, rt, rd, shamt, func, immediate, target) back into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the pipeline's ID-stage field decoder. It sits between the testbench/boot loader front end and the instruction memory write port, and is used to load programs before the pipeline is released. It uses a valid/ready input handshake, a one-stage registered output, an address counter and a session state machine.

## Interface
- `ADDR_W`, 10: instruction memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: opens a load session and reloads the address to `BASE_ADDR`.
- `finish` in 1: closes the session.
- `in_valid` in 1: the field tuple is valid.
- `in_ready` out 1: the encoder accepts a tuple this cycle.
- `fmt` in 2: instruction format; 0 = R, 1 = I, 2 = J, 3 = illegal.
- `op` in 6: opcode field.
- `rs` in 5: rs register field.
- `rt` in 5: rt register field.
- `rd` in 5: rd register field.
- `shamt` in 5: shift amount field.
- `func` in 6: function field.
- `immediate` in 16: immediate field.
- `target` in 26: jump target field.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: encoded instruction word.
- `done` out 1: one-cycle pulse when a session closes.
- `full` out 1: the last address has been written.
- `err` out 1: sticky flag; an illegal `fmt` was accepted.
- `word_count` out ADDR_W+1: words written in the current session.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - LOAD: `in_ready` = !`start`.
  - FULL: `in_ready`=0.
- Accept condition: `in_valid && in_ready`.
- Encoding:
  - R: {op,rs,rt,rd,shamt,func}.
  - I: {op,rs,rt,immediate}.
  - J: {op,target}.
  - Fields not used by the format are ignored.
- Illegal `fmt`: the tuple is accepted and dropped. No write occurs, the address does not change, and `err` is set.
- Address counter:
  - Loaded with `BASE_ADDR` on `start`.
  - Increments by 1 after each write.
  - The write that uses address 2^ADDR_W−1 moves the FSM to FULL and sets `full`. The counter does not wrap.
- Transitions:
  - IDLE→LOAD on `start`.
  - LOAD→IDLE on `finish`.
  - FULL→IDLE on `finish`.
  - Any state→LOAD on `start`: this clears `word_count`, `full` and `err`, and reloads the address.
- `start` and `finish` in the same cycle: `start` wins.
- `finish` together with an accepted tuple in the same cycle: the tuple is written, then the FSM goes to IDLE.
- Reset: state = IDLE. `imem_we`, `imem_addr`, `imem_wdata`, `done`, `full`, `err` and `word_count` all go to 0.
- Reset asserted mid-session: pending writes are discarded and nothing is written afterwards.

## Timing
- An accept sampled at edge k produces `imem_we`=1 during cycle k+1, with `imem_addr` and `imem_wdata` registered.
- `imem_we` is high for exactly one cycle per legal word.
- Throughput: one word per cycle in LOAD.
- `done` pulses in the cycle after `finish` is sampled. It coincides with the final write if that write was accepted with `finish`.
- `word_count` updates in the same cycle as `imem_we`.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0.

## Structure
- Shared package `mips_pkg`:
  - format constants FMT_R, FMT_I, FMT_J, FMT_BAD.
  - FSM state enum.
  - field bit positions: OP 31:26, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNC 5:0, IMM 15:0, TARGET 25:0. These are shared with the ID-stage decoder.
- One combinational sub-module, `instr_pack` (fields + fmt → word, legal flag). The top level holds the FSM, counter and output register.

## Test plan
- Word encodings (start, then one tuple each):
  - R: op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20 → `imem_wdata`=0x00221820 at `BASE_ADDR`, with `imem_we` one cycle after accept.
  - I: op=0x08, rs=0, rt=8, imm=5 → 0x20080005.
  - I: op=0x23, rs=29, rt=8, imm=4 → 0x8FA80004.
  - J: op=2, target=0x10 → 0x08000010.
- Back-to-back: 4 consecutive valid tuples → 4 consecutive `imem_we` cycles at addresses 0,1,2,3 and `word_count`=4.
- Illegal format: tuple with fmt=3 between two legal ones → only 2 writes at consecutive addresses, and `err`=1 until the next `start`.
- Full, with ADDR_W=2: after 4 writes `full`=1 and `in_ready`=0, and a 5th valid tuple is not accepted. `finish` → `done` pulse, state IDLE.
- Boundary and reset:
  - `finish` with a valid tuple → that word is written and `done` pulses in the same cycle.
  - `start` mid-session → the address restarts at `BASE_ADDR`.
  - `rst_n` low mid-stream → all outputs go to 0 immediately and no further writes occur.
